// File: rtl/rv32i_dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32i_dm_pkg                                              |
// | Purpose  : Shared types and constants for the RV32 data-memory block |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package rv32i_dm_pkg;

    // Controller states: accept, count wait states, present response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    // One enable bit per byte of a 32-bit word
    localparam int c_dm_be_w = 4;

    // Load funct3 encodings (same values as the instruction decoder)
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/rv32i_dm_lane_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32i_dm_lane_unit                                        |
// | Purpose  : Byte-lane steering for stores, extraction and extension  |
// |            for loads, plus misalign / illegal-funct3 detection       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rv32i_dm_lane_unit
    import rv32i_dm_pkg::*;
(
    input  logic [2:0]           i_func3,
    input  logic                 i_we,
    input  logic [1:0]           i_off,
    input  logic [31:0]          i_st_data,
    input  logic [31:0]          i_rd_word,
    output logic [c_dm_be_w-1:0] o_be,
    output logic [31:0]          o_wr_data,
    output logic                 o_bad,
    output logic [31:0]          o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rd_word[7:0];
            2'd1:    w_byte = i_rd_word[15:8];
            2'd2:    w_byte = i_rd_word[23:16];
            default: w_byte = i_rd_word[31:24];
        endcase
        w_half = i_off[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    end

    // Decode funct3 into lane enables, replicated store data, load result and error
    always_comb begin
        o_be      = '0;
        o_wr_data = '0;
        o_bad     = 1'b0;
        o_ld_data = '0;
        if (i_we) begin
            case (i_func3)
                c_f3_sb: begin
                    o_be      = 4'b0001 << i_off;
                    o_wr_data = {4{i_st_data[7:0]}};
                end
                c_f3_sh: begin
                    o_be      = 4'b0011 << i_off;
                    o_wr_data = {2{i_st_data[15:0]}};
                    o_bad     = i_off[0];
                end
                c_f3_sw: begin
                    o_be      = 4'b1111;
                    o_wr_data = i_st_data;
                    o_bad     = (i_off != 2'd0);
                end
                default: o_bad = 1'b1;
            endcase
        end else begin
            case (i_func3)
                c_f3_lb:  o_ld_data = {{24{w_byte[7]}}, w_byte};
                c_f3_lbu: o_ld_data = {24'd0, w_byte};
                c_f3_lh: begin
                    o_ld_data = {{16{w_half[15]}}, w_half};
                    o_bad     = i_off[0];
                end
                c_f3_lhu: begin
                    o_ld_data = {16'd0, w_half};
                    o_bad     = i_off[0];
                end
                c_f3_lw: begin
                    o_ld_data = i_rd_word;
                    o_bad     = (i_off != 2'd0);
                end
                default: o_bad = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32i_data_mem_ctrl                                       |
// | Purpose  : Valid/ready data memory with programmable wait states,    |
// |            byte-lane stores and extended loads for the RV32 MEM stage|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rv32i_data_mem_ctrl
    import rv32i_dm_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_dm_req_valid,
    output logic                  o_dm_req_ready,
    input  logic                  i_dm_we,
    input  logic [ADDR_WIDTH-1:0] i_dm_addr,
    input  logic [WIDTH-1:0]      i_dm_data_in,
    input  logic [2:0]            i_dm_func3,
    output logic                  o_dm_rsp_valid,
    input  logic                  i_dm_rsp_ready,
    output logic [WIDTH-1:0]      o_dm_data_out,
    output logic                  o_dm_err
);

    localparam int             c_idx_w    = $clog2(DEPTH);
    localparam logic [3:0]     c_lat_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    // Reject unsupported configurations at elaboration
    generate
        if (WIDTH != 32) begin : g_chk_width
            $error("rv32i_data_mem_ctrl: WIDTH must be 32");
        end
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
            $error("rv32i_data_mem_ctrl: DEPTH must be a power of two >= 4");
        end
        if ((LATENCY < 0) || (LATENCY > 15)) begin : g_chk_latency
            $error("rv32i_data_mem_ctrl: LATENCY must be in 0..15");
        end
    endgenerate

    dm_state_t              r_state;
    dm_state_t              w_state_nxt;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [WIDTH-1:0]       r_wdata;
    logic [2:0]             r_func3;
    logic [WIDTH-1:0]       r_rdata;
    logic                   r_err;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [WIDTH-1:0]       w_wdata;
    logic [2:0]             w_func3;
    logic [c_idx_w-1:0]     w_idx;
    logic                   w_oor;
    logic                   w_bad;
    logic                   w_err;
    logic [c_dm_be_w-1:0]   w_be;
    logic [WIDTH-1:0]       w_wr_data;
    logic [WIDTH-1:0]       w_ld_data;

    assign w_accept = (r_state == IDLE) && i_dm_req_valid;
    // With zero wait states the commit happens on the accept edge itself
    assign w_commit = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));

    // The committing transaction is the live request when committing from IDLE
    assign w_we    = (r_state == IDLE) ? i_dm_we      : r_we;
    assign w_addr  = (r_state == IDLE) ? i_dm_addr    : r_addr;
    assign w_wdata = (r_state == IDLE) ? i_dm_data_in : r_wdata;
    assign w_func3 = (r_state == IDLE) ? i_dm_func3   : r_func3;

    assign w_idx = w_addr[c_idx_w+1:2];
    assign w_oor = (w_addr >> (c_idx_w + 2)) != '0;
    assign w_err = w_bad | w_oor;

    rv32i_dm_lane_unit u_lane (
        .i_func3   (w_func3),
        .i_we      (w_we),
        .i_off     (w_addr[1:0]),
        .i_st_data (w_wdata),
        .i_rd_word (r_mem[w_idx]),
        .o_be      (w_be),
        .o_wr_data (w_wr_data),
        .o_bad     (w_bad),
        .o_ld_data (w_ld_data)
    );

    assign o_dm_req_ready = (r_state == IDLE);
    assign o_dm_rsp_valid = (r_state == RESP);
    assign o_dm_data_out  = r_rdata;
    assign o_dm_err       = r_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: one transaction in flight, response held until taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_dm_req_valid) w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (i_dm_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the request on accept and count down the wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_func3 <= 3'd0;
        end else if (w_accept) begin
            r_cnt   <= c_lat_init;
            r_we    <= i_dm_we;
            r_addr  <= i_dm_addr;
            r_wdata <= i_dm_data_in;
            r_func3 <= i_dm_func3;
        end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Register the response on commit; stores and errors return zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (!w_we && !w_err) ? w_ld_data : '0;
        end
    end

    // Memory array: byte-enabled write on commit, never on an erroring access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit && w_we && !w_err) begin
            for (int b = 0; b < c_dm_be_w; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire
